// File: rtl/seq_recurrence_decoder_pkg.sv
// seq_recurrence_decoder_pkg: shared states, widths and the generator's square term
package seq_recurrence_decoder_pkg;
    localparam int SAMPLE_W = 8;
    localparam int K_W = 6;
    localparam logic [SAMPLE_W-1:0] K_MAX = 63;
    typedef enum logic [1:0] {EMPTY, PRIMED, TRACK, LOCKED} state_t;
    function automatic logic [SAMPLE_W-1:0] sq(input logic [SAMPLE_W-1:0] a);
        return {3'b0, a[7:3]} * {3'b0, a[7:3]};
    endfunction
endpackage

// File: rtl/seq_delta_calc.sv
// seq_delta_calc: combinational step recovery and next-value prediction
module seq_delta_calc
    import seq_recurrence_decoder_pkg::*;
(
    input  logic [SAMPLE_W-1:0] prev,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [K_W-1:0]      k,
    output logic [SAMPLE_W-1:0] delta,
    output logic                delta_valid,
    output logic [SAMPLE_W-1:0] pred
);
    logic [SAMPLE_W-1:0] sq_prev;
    assign sq_prev     = sq(prev);
    assign delta       = sample - prev - sq_prev;
    assign delta_valid = delta <= K_MAX;
    // Prediction is based on the incoming sample, which becomes prev once registered
    assign pred        = sample + sq(sample) + {2'b0, k};
endmodule

// File: rtl/seq_recurrence_decoder.sv
// seq_recurrence_decoder: acquires and tracks the step k of the A(n) recurrence
module seq_recurrence_decoder
    import seq_recurrence_decoder_pkg::*;
#(
    parameter int LOCK_COUNT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic                resync,
    output logic [K_W-1:0]      k_out,
    output logic                locked,
    output logic                mismatch,
    output logic [SAMPLE_W-1:0] predicted,
    output logic [7:0]          err_count
);
    state_t state, state_n;
    logic [SAMPLE_W-1:0] prev, delta, pred;
    logic [K_W-1:0] cand, cand_n, k_n;
    logic [3:0] match_cnt, cnt_n;
    logic delta_valid, loss;

    seq_delta_calc u_calc (
        .prev(prev),
        .sample(sample_in),
        .k(k_n),
        .delta(delta),
        .delta_valid(delta_valid),
        .pred(pred)
    );

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = match_cnt;
        k_n     = k_out;
        loss    = 1'b0;
        unique case (state)
            EMPTY:  state_n = PRIMED;
            PRIMED: if (delta_valid) begin
                cand_n  = delta[K_W-1:0];
                cnt_n   = 4'd1;
                state_n = TRACK;
            end
            TRACK: if (delta_valid && delta[K_W-1:0] == cand) begin
                cnt_n = match_cnt + 4'd1;
                if (cnt_n == 4'(LOCK_COUNT)) begin
                    state_n = LOCKED;
                    k_n     = cand;
                end
            end else if (delta_valid) begin
                cand_n = delta[K_W-1:0];
                cnt_n  = 4'd1;
            end else begin
                state_n = PRIMED;
            end
            LOCKED: if (delta != {2'b0, k_out}) begin
                loss    = 1'b1;
                state_n = delta_valid ? TRACK : PRIMED;
                cand_n  = delta_valid ? delta[K_W-1:0] : cand;
                cnt_n   = delta_valid ? 4'd1 : match_cnt;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            prev      <= '0;
            cand      <= '0;
            match_cnt <= '0;
            k_out     <= '0;
            locked    <= 1'b0;
            mismatch  <= 1'b0;
            predicted <= '0;
            err_count <= '0;
        end else if (resync) begin
            state     <= EMPTY;
            cand      <= '0;
            match_cnt <= '0;
            locked    <= 1'b0;
            mismatch  <= 1'b0;
            predicted <= '0;
        end else if (sample_valid) begin
            state     <= state_n;
            prev      <= sample_in;
            cand      <= cand_n;
            match_cnt <= cnt_n;
            k_out     <= k_n;
            locked    <= state_n == LOCKED;
            mismatch  <= loss;
            predicted <= state_n == LOCKED ? pred : '0;
            err_count <= (loss && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
        end else begin
            mismatch  <= 1'b0;
        end
    end
endmodule

// File: doc/seq_recurrence_decoder.md
SEQ_RECURRENCE_DECODER -- requirements
Module: seq_recurrence_decoder

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 4, number of consecutive equal valid deltas needed to declare lock (legal 2..15).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sample_in  input  8  observed recurrence value A(n).
REQ-005 SHALL have port sample_valid  input  1  sample_in accepted on any rising edge where high.
REQ-006 SHALL have port resync  input  1  single-cycle request to discard history and re-acquire.
REQ-007 SHALL have port k_out  output  6  recovered step k (k = ui_in>>2 of the generator).
REQ-008 SHALL have port locked  output  1  high while in LOCKED.
REQ-009 SHALL have port mismatch  output  1  one-cycle pulse on loss of lock.
REQ-010 SHALL have port predicted  output  8  expected next sample while locked, else 0.
REQ-011 SHALL have port err_count  output  8  saturating count of loss-of-lock events.

Function
REQ-012 SHALL model generator A(n+1) = (A(n) + k + sq) mod 256, with sq = ((A(n)>>3)*(A(n)>>3)) mod 256.
REQ-013 SHALL compute delta = (sample_in - prev - sq(prev)) mod 256, 8-bit wrap; delta is valid only if delta <= 63.
REQ-014 SHALL update prev <= sample_in on every accepted sample, in every state.
REQ-015 SHALL implement states EMPTY, PRIMED, TRACK, LOCKED; EMPTY after reset.
REQ-016 EMPTY: accepted sample -> PRIMED.
REQ-017 PRIMED: valid delta -> cand <= delta, match_cnt <= 1, TRACK; invalid delta -> stay PRIMED.
REQ-018 TRACK: delta == cand -> match_cnt+1; if that equals LOCK_COUNT -> LOCKED, k_out <= cand; valid delta != cand -> cand <= delta, match_cnt <= 1, stay; invalid -> PRIMED.
REQ-019 LOCKED: delta == k_out -> stay; otherwise mismatch pulse, err_count saturating +1 (holds at 255), then TRACK with cand <= delta, match_cnt <= 1 if valid, else PRIMED.
REQ-020 k_out SHALL hold its last locked value until the next lock; locked SHALL equal (state == LOCKED).
REQ-021 All outputs SHALL be registered; effect of a sample visible the cycle after acceptance (latency 1).
REQ-022 predicted SHALL be (prev + sq(prev) + k_out) mod 256, registered, updated on each accepted sample when entering or remaining in LOCKED; 0 in other states.
REQ-023 sample_valid low SHALL freeze all state and outputs; mismatch SHALL be low.
REQ-024 resync high SHALL force EMPTY, clear locked, predicted, match_cnt, cand; SHALL keep err_count and k_out; resync wins over a simultaneous sample_valid (sample discarded).

Reset
REQ-025 reset SHALL set state EMPTY, prev 0, cand 0, match_cnt 0, k_out 0, locked 0, mismatch 0, predicted 0, err_count 0; reset wins over all other inputs.
REQ-026 reset asserted mid-LOCKED SHALL give all-zero outputs the following cycle.

Structure
REQ-027 Shared package SHALL hold the state enum, K_MAX = 63, sample width 8, k width 6.
REQ-028 One combinational sub-module seq_delta_calc SHALL compute sq(prev), delta, delta_valid and next-value prediction; all sequencing lives in the top.

Verification
REQ-029 LOCK_COUNT=4, samples 0,5,10,16,25 -> locked=1, k_out=5, predicted=39 the cycle after sample 25.
REQ-030 Locked at k=5 with prev=25, sample 40 -> mismatch one cycle, err_count=1, state TRACK with cand=6, locked=0.
REQ-031 Locked, prev=25, sample 200 (delta 166) -> mismatch, err_count+1, state PRIMED.
REQ-032 Wrap: samples 250 repeated five times -> delta 63 each step, locked=1, k_out=63, predicted=250.
REQ-033 Force 256 loss-of-lock events -> err_count saturates at 255; then resync with simultaneous sample_valid -> EMPTY, sample ignored, err_count stays 255.
REQ-034 reset asserted while LOCKED with sample_valid high -> next cycle all outputs 0, state EMPTY.
